// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side request/completion signals of the load/store unit.
// The master side is the core plus memory environment; the slave side is the LSU itself.
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output req, we, funct3, addr, wdata, mem_ready, mem_rdata,
        input  stall, rdata, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_ready, mem_rdata,
        output stall, rdata, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-lane steering, load extension and a timeout abort.
// Latency is 2 cycles minimum (IDLE->WAIT->DONE); the core is stalled until mem_ready or the timeout.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_abort;
    logic          r_we;
    logic [2:0]    r_funct3;
    logic [1:0]    r_off;
    logic [3:0]    r_be;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;

    logic          w_legal, w_aligned, w_accept, w_reject, w_timeout;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_word;
    logic [31:0]   w_load;

    always_comb begin
        w_legal = 1'b0;
        if (bus.we) begin
            w_legal = (bus.funct3 <= 3'b010);
        end else begin
            case (bus.funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                default:                                w_legal = 1'b0;
            endcase
        end

        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = bus.wdata;
        case (bus.funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << bus.addr[1:0];
                w_wdata = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                w_aligned = ~bus.addr[0];
                w_be      = bus.addr[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{bus.wdata[15:0]}};
            end
            default: w_aligned = (bus.addr[1:0] == 2'b00);
        endcase
    end

    assign w_accept = (r_state == S_IDLE) & bus.req & w_legal & w_aligned;
    assign w_reject = (r_state == S_IDLE) & bus.req & ~(w_legal & w_aligned);

    // Shift the addressed lane down to bit 0, then extend by the captured width code.
    assign w_word = bus.mem_rdata >> {r_off, 3'b000};
    always_comb begin
        w_load = w_word;
        case (r_funct3)
            3'b000:  w_load = {{24{w_word[7]}}, w_word[7:0]};
            3'b001:  w_load = {{16{w_word[15]}}, w_word[15:0]};
            3'b100:  w_load = {24'h0, w_word[7:0]};
            3'b101:  w_load = {16'h0, w_word[15:0]};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.mem_ready) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_DONE;
                    w_timeout   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_abort  <= 1'b0;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_off    <= 2'b00;
            r_be     <= 4'b0000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
        end else begin
            if (w_accept) begin
                r_cnt    <= '0;
                r_abort  <= 1'b0;
                r_we     <= bus.we;
                r_funct3 <= bus.funct3;
                r_off    <= bus.addr[1:0];
                r_be     <= w_be;
                r_addr   <= {bus.addr[31:2], 2'b00};
                r_wdata  <= w_wdata;
            end else if (r_state == S_WAIT) begin
                if (bus.mem_ready) begin
                    r_rdata <= r_we ? 32'h0 : w_load;
                end else if (w_timeout) begin
                    r_abort <= 1'b1;
                    r_rdata <= 32'h0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.mem_req   = (r_state == S_WAIT);
    assign bus.mem_we    = r_we;
    assign bus.mem_be    = r_be;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.rdata     = r_rdata;
    assign bus.stall     = w_accept | (r_state == S_WAIT);
    assign bus.err       = ((r_state == S_DONE) & r_abort) | w_reject;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lane steering, extension, rejection, timeout and reset mid-access.
module tb_load_store_unit;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total  = 0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req    = r;
        bus.we     = w;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.wdata  = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;

        // reset state
        #3;
        check("rst_mem_req",   {31'h0, bus.mem_req}, 32'h0);
        check("rst_mem_we",    {31'h0, bus.mem_we},  32'h0);
        check("rst_mem_be",    {28'h0, bus.mem_be},  32'h0);
        check("rst_mem_addr",  bus.mem_addr,         32'h0);
        check("rst_mem_wdata", bus.mem_wdata,        32'h0);
        check("rst_rdata",     bus.rdata,            32'h0);
        check("rst_err",       {31'h0, bus.err},     32'h0);
        #9 reset = 1'b1;

        // lb at 0x103: top byte 0x80 sign-extends
        step();
        drive(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
        #1;
        check("lb_stall_idle", {31'h0, bus.stall},   32'h1);
        check("lb_noreq_idle", {31'h0, bus.mem_req}, 32'h0);
        step();
        check("lb_mem_req",  {31'h0, bus.mem_req}, 32'h1);
        check("lb_mem_be",   {28'h0, bus.mem_be},  32'h8);
        check("lb_mem_addr", bus.mem_addr,         32'h0000_0100);
        check("lb_stall_wait", {31'h0, bus.stall}, 32'h1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h80FF_1234;
        step();
        check("lb_rdata",      bus.rdata,            32'hFFFF_FF80);
        check("lb_stall_done", {31'h0, bus.stall},   32'h0);
        check("lb_err_done",   {31'h0, bus.err},     32'h0);
        check("lb_mem_req_dn", {31'h0, bus.mem_req}, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();

        // mem_ready while idle is ignored
        #1;
        check("idle_ready_req",   {31'h0, bus.mem_req}, 32'h0);
        step();
        check("idle_ready_stall", {31'h0, bus.stall},   32'h0);
        bus.mem_ready = 1'b0;

        // sh at 0x22, held in WAIT for three cycles
        drive(1'b1, 1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD);
        step();
        check("sh_mem_addr",  bus.mem_addr,         32'h0000_0020);
        check("sh_mem_be",    {28'h0, bus.mem_be},  32'hC);
        check("sh_mem_wdata", bus.mem_wdata,        32'hABCD_ABCD);
        check("sh_mem_we",    {31'h0, bus.mem_we},  32'h1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("sh_hold_req",   {31'h0, bus.mem_req}, 32'h1);
            check("sh_hold_wdata", bus.mem_wdata,        32'hABCD_ABCD);
            check("sh_hold_be",    {28'h0, bus.mem_be},  32'hC);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        step();
        check("sh_rdata_zero", bus.rdata,          32'h0);
        check("sh_stall_done", {31'h0, bus.stall}, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.mem_ready = 1'b0;
        step();

        // lhu at 0x42: upper half zero-extended
        drive(1'b1, 1'b0, 3'b101, 32'h0000_0042, 32'h0);
        step();
        check("lhu_mem_be", {28'h0, bus.mem_be}, 32'hC);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h9ABC_0000;
        step();
        check("lhu_rdata", bus.rdata, 32'h0000_9ABC);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.mem_ready = 1'b0;
        step();

        // lh at 0x02: upper half sign-extended
        drive(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0);
        step();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h8001_7F00;
        step();
        check("lh_rdata", bus.rdata, 32'hFFFF_8001);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.mem_ready = 1'b0;
        step();

        // lbu at 0x01
        drive(1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0);
        step();
        check("lbu_mem_be", {28'h0, bus.mem_be}, 32'h2);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1122_F344;
        step();
        check("lbu_rdata", bus.rdata, 32'h0000_00F3);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.mem_ready = 1'b0;
        step();

        // sb at 0x03: byte replicated on all lanes
        drive(1'b1, 1'b1, 3'b000, 32'h0000_0003, 32'hAABB_CC5A);
        step();
        check("sb_mem_be",    {28'h0, bus.mem_be}, 32'h8);
        check("sb_mem_wdata", bus.mem_wdata,       32'h5A5A_5A5A);
        bus.mem_ready = 1'b1;
        step();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.mem_ready = 1'b0;
        step();

        // misaligned lw is rejected in IDLE
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
        #1;
        check("lw_mis_err",   {31'h0, bus.err},   32'h1);
        check("lw_mis_stall", {31'h0, bus.stall}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lw_mis_noreq", {31'h0, bus.mem_req}, 32'h0);
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check("lw_mis_err_clr", {31'h0, bus.err}, 32'h0);

        // illegal store width code
        drive(1'b1, 1'b1, 3'b011, 32'h0000_0000, 32'h0);
        #1;
        check("st_ill_err",   {31'h0, bus.err},   32'h1);
        check("st_ill_stall", {31'h0, bus.stall}, 32'h0);
        step();
        check("st_ill_noreq", {31'h0, bus.mem_req}, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();

        // timeout: mem_ready never arrives
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
        step();
        n = 0;
        while (bus.mem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("to_wait_cycles", n,                  32'd16);
        check("to_err",         {31'h0, bus.err},   32'h1);
        check("to_rdata",       bus.rdata,          32'h0);
        check("to_stall",       {31'h0, bus.stall}, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();
        check("to_err_idle", {31'h0, bus.err},     32'h0);
        check("to_idle_req", {31'h0, bus.mem_req}, 32'h0);

        // reset pulsed mid-WAIT, then a normal lw
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0030, 32'h0);
        step();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check("rw_mem_req_pre", {31'h0, bus.mem_req}, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("rw_mem_req",  {31'h0, bus.mem_req}, 32'h0);
        check("rw_mem_addr", bus.mem_addr,         32'h0);
        check("rw_mem_be",   {28'h0, bus.mem_be},  32'h0);
        #1 reset = 1'b1;
        step();
        check("rw_idle_req", {31'h0, bus.mem_req}, 32'h0);
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0034, 32'h0);
        step();
        check("rw_lw_addr", bus.mem_addr,        32'h0000_0034);
        check("rw_lw_be",   {28'h0, bus.mem_be}, 32'hF);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        check("rw_lw_rdata", bus.rdata,        32'hDEAD_BEEF);
        check("rw_lw_err",   {31'h0, bus.err}, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.mem_ready = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum number of WAIT cycles without mem_ready before the access aborts; legal range 2..256.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-004 SHALL have port req  input  1  core requests a load or store; held stable while stall=1.
REQ-005 SHALL have port we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port funct3  input  3  RV32I width code: load 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store 000 sb, 001 sh, 010 sw.
REQ-007 SHALL have ports addr and wdata  input  32 each  byte address and store data (rs2).
REQ-008 SHALL have port stall  output  1  freezes the core PC and register write while 1.
REQ-009 SHALL have port rdata  output  32  extended load result, valid in DONE.
REQ-010 SHALL have port err  output  1  one-cycle access-fault pulse.
REQ-011 SHALL have ports mem_req, mem_we  output  1 each; mem_be  output  4; mem_addr, mem_wdata  output  32 each  memory-side request.
REQ-012 SHALL have ports mem_ready  input  1 and mem_rdata  input  32  memory completion and read word.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-014 In IDLE with req=1 and a legal, aligned access, the unit SHALL capture mem_addr={addr[31:2],2'b00}, mem_we, mem_be, mem_wdata, addr[1:0] and funct3, then enter WAIT.
REQ-015 Byte enables SHALL be: sb → 4'b0001<<addr[1:0]; sh → addr[1] ? 1100 : 0011; sw, lw → 1111; lb/lbu → one-hot by addr[1:0]; lh/lhu → as sh.
REQ-016 Store data SHALL be lane-replicated: sb → {4{wdata[7:0]}}; sh → {2{wdata[15:0]}}; sw → wdata.
REQ-017 mem_req SHALL be 1 only in WAIT, and all mem_* outputs SHALL hold stable during WAIT.
REQ-018 WAIT SHALL exit to DONE on the first edge at which mem_ready=1; for a load, the unit SHALL register mem_rdata at that edge.
REQ-019 A WAIT cycle counter SHALL clear on WAIT entry; if it reaches TIMEOUT-1 with mem_ready=0, the unit SHALL abort to DONE with the error flag set and rdata=0.
REQ-020 rdata SHALL be the selected byte or halfword, sign-extended (lb, lh) or zero-extended (lbu, lhu); lw SHALL return the full word; stores SHALL return rdata=0.
REQ-021 err SHALL be 1 only in the DONE cycle of an aborted access, or combinationally in IDLE for a rejected access.
REQ-022 DONE SHALL last exactly one cycle with stall=0, then go to IDLE unconditionally.
REQ-023 stall SHALL equal (req & IDLE & access accepted) | WAIT, computed combinationally, so the requesting cycle is already stalled.
REQ-024 A misaligned access (h: addr[0]≠0; w: addr[1:0]≠0) or an illegal funct3 (load 011/110/111; store ≥011) SHALL be rejected in IDLE: no mem_req, stall=0, err=1 that cycle, state stays IDLE.
REQ-025 A successful access SHALL take minimum latency 2 cycles (IDLE→WAIT→DONE with mem_ready=1 on the first WAIT cycle); back-to-back requests SHALL resume from IDLE the cycle after DONE.
REQ-026 mem_ready while not in WAIT SHALL be ignored.
REQ-027 req=0 in IDLE SHALL produce no memory activity.

Reset
REQ-028 reset=0 SHALL force state IDLE, counter 0, and mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rdata=0, err=0, regardless of clk.
REQ-029 Reset asserted mid-WAIT SHALL abandon the access with no completion, and the first request after reset release SHALL be serviced normally.

Verification
REQ-030 lb: addr=0x103, mem_rdata=0x80FF_1234, mem_ready on first WAIT cycle → mem_be=1000, rdata=0xFFFF_FF80 in DONE, 2 stall cycles.
REQ-031 sh: addr=0x22, wdata=0x1234_ABCD → mem_addr=0x20, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1, outputs stable across 3 wait cycles.
REQ-032 lhu: addr=0x42, mem_rdata=0x9ABC_0000 → rdata=0x0000_9ABC.
REQ-033 lw: addr=0x06 → err=1, stall=0, mem_req never asserts.
REQ-034 mem_ready held 0 with TIMEOUT=16 → DONE after 16 WAIT cycles with err=1, rdata=0, then IDLE.
REQ-035 reset=0 pulsed during WAIT between edges → mem_req drops immediately, and the next lw completes correctly.
